// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Holds the FSM state encoding and the latched-request record.
package data_ram_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              grant;
    } arb_req_t;

    function automatic arb_req_t make_req(
        input logic              we,
        input logic [SEL_W-1:0]  sel,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic              grant
    );
        arb_req_t r;
        r.we    = we;
        r.sel   = sel;
        r.addr  = addr;
        r.wdata = wdata;
        r.grant = grant;
        return r;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Combinational two-way pick: round-robin on a tie when enabled,
// otherwise port 0 takes every tie.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       rr_en_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = rr_en_i ? ~last_grant_i : 1'b0;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Serialises CPU (port 0) and loader (port 1) accesses onto the single-port
// data RAM: IDLE -> ACCESS -> RESP, one transaction every three cycles.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              stallreq_o,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e        state_q, state_d;
    arb_req_t          lat_q, lat_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic              grant;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .rr_en_i      (RR_EN),
        .grant_o      (grant)
    );

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                // Ports are sampled only here; later changes never reach the RAM.
                if (m0_req || m1_req) begin
                    state_d      = ARB_ACCESS;
                    last_grant_d = grant;
                    lat_d        = grant ? make_req(m1_we, m1_sel, m1_addr, m1_wdata, 1'b1)
                                         : make_req(m0_we, m0_sel, m0_addr, m0_wdata, 1'b0);
                end
            end
            ARB_ACCESS: state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            lat_q        <= '0;
            last_grant_q <= 1'b1;
            m0_rdata_q   <= ZERO_WORD;
            m1_rdata_q   <= ZERO_WORD;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            last_grant_q <= last_grant_d;
            if (state_q == ARB_ACCESS && !lat_q.we) begin
                if (lat_q.grant) begin
                    m1_rdata_q <= ram_rdata;
                end else begin
                    m0_rdata_q <= ram_rdata;
                end
            end
        end
    end

    // Reset gates the chip enable so an interrupted write never lands.
    assign ram_ce    = (state_q == ARB_ACCESS) && !rst;
    assign ram_we    = ram_ce && lat_q.we;
    assign ram_sel   = lat_q.sel;
    assign ram_addr  = lat_q.addr;
    assign ram_wdata = lat_q.wdata;

    assign m0_ack     = (state_q == ARB_RESP) && !lat_q.grant;
    assign m1_ack     = (state_q == ARB_RESP) &&  lat_q.grant;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign stallreq_o = m0_req & ~m0_ack;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus,
// each with its own byte-lane RAM model; acks are checked against a queue.
module tb_data_ram_arbiter;
    import data_ram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0]  m0_sel = 0, m1_sel = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic        a_m0_ack, a_m1_ack, a_stall, a_ram_ce, a_ram_we;
    logic [3:0]  a_ram_sel;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic        b_m0_ack, b_m1_ack, b_stall, b_ram_ce, b_ram_we;
    logic [3:0]  b_ram_sel;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    int vectors = 0;
    int miscompares = 0;
    logic use_fp = 1'b0;
    logic [31:0] last_rd [2];

    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    data_ram_arbiter #(.RR_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .stallreq_o(a_stall), .ram_ce(a_ram_ce), .ram_we(a_ram_we), .ram_sel(a_ram_sel),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
    );

    data_ram_arbiter #(.RR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .stallreq_o(b_stall), .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_sel(b_ram_sel),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // Byte-lane RAM models with combinational read.
    assign a_ram_rdata = mem_a[a_ram_addr[7:2]];
    assign b_ram_rdata = mem_b[b_ram_addr[7:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (a_ram_ce && a_ram_we && a_ram_sel[b]) mem_a[a_ram_addr[7:2]][8*b +: 8] <= a_ram_wdata[8*b +: 8];
            if (b_ram_ce && b_ram_we && b_ram_sel[b]) mem_b[b_ram_addr[7:2]][8*b +: 8] <= b_ram_wdata[8*b +: 8];
        end
    end

    wire        sel_ack0   = use_fp ? b_m0_ack   : a_m0_ack;
    wire        sel_ack1   = use_fp ? b_m1_ack   : a_m1_ack;
    wire [31:0] sel_rdata0 = use_fp ? b_m0_rdata : a_m0_rdata;
    wire [31:0] sel_rdata1 = use_fp ? b_m1_rdata : a_m1_rdata;
    wire        sel_stall  = use_fp ? b_stall    : a_stall;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (sel_ack0 || sel_ack1)) begin
            sb_t e;
            if (sel_ack0 && sel_ack1) check_val("dual_ack", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("ack_port", {31'd0, sel_ack1}, {31'd0, e.port});
                if (e.rd) begin
                    check_val("rdata", e.port ? sel_rdata1 : sel_rdata0, e.data);
                    last_rd[e.port] = e.data;
                end else begin
                    check_val("wr_rdata_hold", e.port ? sel_rdata1 : sel_rdata0, last_rd[e.port]);
                end
                $display("txn port=%0d rd=%0d data=0x%08h", e.port, e.rd, e.data);
            end
        end
    end

    task automatic drive_port(input logic port, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_req = 1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic push_exp(input logic port, input logic rd, input logic [31:0] data);
        sb_t e;
        e.port = port; e.rd = rd; e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        last_rd[0] = 0; last_rd[1] = 0;
        rst = 0;
    endtask

    // One transaction from an idle FSM; checks two-cycle ack latency and CPU stall.
    task automatic single(input logic port, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        int  n = 0;
        bit  got = 0;
        @(negedge clk);
        drive_port(port, we, sel, addr, wdata);
        push_exp(port, !we, exp);
        #1;
        if (!port) check_val("stall_c0", {31'd0, sel_stall}, 32'd1);
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (port ? sel_ack1 : sel_ack0) got = 1;
            else if (!port && n == 1) check_val("stall_c1", {31'd0, sel_stall}, 32'd1);
        end
        check_val("ack_latency", n, 2);
        if (!port) check_val("stall_ack", {31'd0, sel_stall}, 32'd0);
        if (port) m1_req = 0; else m0_req = 0;
    endtask

    initial begin
        int acks, n, last, ce_cnt;
        last_rd[0] = 0; last_rd[1] = 0;
        repeat (3) @(negedge clk);
        check_val("rst_ack0", {31'd0, a_m0_ack}, 32'd0);
        check_val("rst_ack1", {31'd0, a_m1_ack}, 32'd0);
        check_val("rst_rdata0", a_m0_rdata, 32'd0);
        check_val("rst_ce", {31'd0, a_ram_ce}, 32'd0);
        check_val("rst_state", {30'd0, dut_a.state_q}, {30'd0, ARB_IDLE});
        check_val("rst_last_grant", {31'd0, dut_a.last_grant_q}, 32'd1);
        rst = 0;

        // 1: word write then read on port 0
        single(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0);
        single(0, 0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF);
        // 2: byte-lane write, plus a zero-lane write that must change nothing
        single(1, 1, 4'b1111, 32'h20, 32'h11223344, 32'h0);
        single(0, 1, 4'b0100, 32'h20, 32'h00AA0000, 32'h0);
        single(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h0);
        single(0, 0, 4'b1111, 32'h20, 32'h0, 32'h11AA3344);
        single(1, 0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF);

        // 3: round-robin with both ports held
        do_reset();
        @(negedge clk);
        drive_port(0, 0, 4'hF, 32'h10, 32'h0);
        drive_port(1, 0, 4'hF, 32'h20, 32'h0);
        push_exp(0, 1, 32'hDEADBEEF); push_exp(1, 1, 32'h11AA3344);
        push_exp(0, 1, 32'hDEADBEEF); push_exp(1, 1, 32'h11AA3344);
        acks = 0; n = 0; last = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (sel_ack0 || sel_ack1) begin
                acks++;
                if (acks > 1) check_val("rr_gap", n - last, 3);
                last = n;
            end
        end
        m0_req = 0; m1_req = 0;
        check_val("rr_acks", acks, 4);
        repeat (4) @(negedge clk);

        // 4: fixed priority, port 1 only after port 0 lets go
        use_fp = 1;
        do_reset();
        @(negedge clk);
        drive_port(0, 0, 4'hF, 32'h10, 32'h0);
        drive_port(1, 0, 4'hF, 32'h20, 32'h0);
        push_exp(0, 1, 32'hDEADBEEF); push_exp(0, 1, 32'hDEADBEEF);
        push_exp(0, 1, 32'hDEADBEEF); push_exp(1, 1, 32'h11AA3344);
        acks = 0; n = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (sel_ack0 || sel_ack1) begin
                acks++;
                if (acks == 3) m0_req = 0;
            end
        end
        m0_req = 0; m1_req = 0;
        check_val("fp_acks", acks, 4);
        repeat (4) @(negedge clk);
        use_fp = 0;
        do_reset();

        // 5: reset in the ACCESS cycle of a port-1 write
        single(1, 1, 4'b1111, 32'h30, 32'h5A5A5A5A, 32'h0);
        @(negedge clk);
        drive_port(1, 1, 4'b1111, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        check_val("access_ce", {31'd0, a_ram_ce}, 32'd1);
        rst = 1; m1_req = 0;
        #1;
        check_val("rst_gate_ce", {31'd0, a_ram_ce}, 32'd0);
        check_val("rst_gate_we", {31'd0, a_ram_we}, 32'd0);
        @(negedge clk);
        check_val("rst_state_idle", {30'd0, dut_a.state_q}, {30'd0, ARB_IDLE});
        check_val("rst_no_ack", {31'd0, a_m1_ack}, 32'd0);
        last_rd[0] = 0; last_rd[1] = 0;
        rst = 0;
        repeat (3) @(negedge clk);
        single(1, 0, 4'b1111, 32'h30, 32'h0, 32'h5A5A5A5A);

        // 6: req dropped during ACCESS; unaligned address passes through
        @(negedge clk);
        drive_port(0, 0, 4'b1111, 32'h13, 32'h0);
        push_exp(0, 1, 32'hDEADBEEF);
        @(negedge clk);
        check_val("addr_pass", a_ram_addr, 32'h13);
        m0_req = 0;
        @(negedge clk);
        check_val("drop_ack", {31'd0, a_m0_ack}, 32'd1);
        ce_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ram_ce) ce_cnt++;
        end
        check_val("no_second_txn", ce_cnt, 0);
        check_val("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
